chan_div_iter: RTL

CHAN_DIV_ITER -- requirements
Module: chan_div_iter

---
 rtl/chan_div_pkg.sv | 7 +
 rtl/chan_div_lane.sv | 86 ++++++++
 rtl/chan_div_iter.sv | 71 +++++++
 3 files changed

// File: rtl/chan_div_pkg.sv
// chan_div_pkg: shared state encoding and iteration-count helper for chan_div_iter
package chan_div_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int ceil_div(input int x, input int y);
    return (x + y - 1) / y;
  endfunction
endpackage

// File: rtl/chan_div_lane.sv
// chan_div_lane: one channel of restoring division, STEP bits per cycle, MSB first.
// Define CHAN_DIV_ROUND_EN to round the quotient half-up instead of truncating.
module chan_div_lane
  import chan_div_pkg::*;
#(
  parameter int A_W = 16,
  parameter int B_W = 8,
  parameter int Q_W = 8,
  parameter int STEP = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic zero,
  input  logic run,
  input  logic fin,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [Q_W-1:0] q,
  output logic sat
);
  localparam int N = ceil_div(A_W, STEP);
  localparam int LAST = A_W - (N - 1) * STEP;
  logic [B_W-1:0] rem, r;
  logic [A_W-1:0] dvd, d, quo, qq;
  logic [B_W:0] t;
  logic ge;
  logic [A_W:0] full;
  logic [Q_W-1:0] q_n;
  logic sat_n;
  // the final cycle only consumes the bits that remain after the full-width steps
  always_comb begin
    r = rem;
    d = dvd;
    qq = quo;
    t = '0;
    ge = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (!fin || i < LAST) begin
        t = {r, d[A_W-1]};
        d = d << 1;
        ge = t >= {1'b0, b};
        t = ge ? t - {1'b0, b} : t;
        r = t[B_W-1:0];
        qq = {qq[A_W-2:0], ge};
      end
    end
  end
`ifdef CHAN_DIV_ROUND_EN
  logic up;
  always_comb begin
    up = {r, 1'b0} >= {1'b0, b};
    full = {1'b0, qq} + {{A_W{1'b0}}, up};
  end
`else
  always_comb full = {1'b0, qq};
`endif
  always_comb begin
    sat_n = |full[A_W:Q_W];
    q_n = sat_n ? '1 : full[Q_W-1:0];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rem <= '0;
      dvd <= '0;
      quo <= '0;
      q <= '0;
      sat <= 1'b0;
    end else if (load) begin
      rem <= '0;
      dvd <= a;
      quo <= '0;
      if (zero) begin
        q <= '1;
        sat <= 1'b0;
      end
    end else if (run) begin
      rem <= r;
      dvd <= d;
      quo <= qq;
      if (fin) begin
        q <= q_n;
        sat <= sat_n;
      end
    end
endmodule

// File: rtl/chan_div_iter.sv
// chan_div_iter: NUM_CH dividends divided by one shared divisor, iterative, valid/ready handshake.
// Define CHAN_DIV_ROUND_EN to round quotients half-up instead of truncating.
module chan_div_iter
  import chan_div_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int A_W = 16,
  parameter int B_W = 8,
  parameter int Q_W = 8,
  parameter int STEP = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [NUM_CH*A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic out_valid,
  input  logic out_ready,
  output logic [NUM_CH*Q_W-1:0] q,
  output logic [NUM_CH-1:0] sat,
  output logic dz
);
  localparam int N = ceil_div(A_W, STEP);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [B_W-1:0] b_r;
  logic accept, zload, run, fin;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (state == IDLE && in_valid) nxt = (b == '0) ? DONE : BUSY;
    else if (state == BUSY && fin) nxt = DONE;
    else if (state == DONE && out_ready) nxt = IDLE;
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    run = state == BUSY;
    accept = in_ready && in_valid;
    zload = accept && b == '0;
    fin = run && cnt == CW'(N - 1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      b_r <= '0;
      dz <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      b_r <= b;
      dz <= b == '0;
    end else if (run) cnt <= cnt + 1'b1;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    chan_div_lane #(.A_W(A_W), .B_W(B_W), .Q_W(Q_W), .STEP(STEP)) u_lane (
      .clk(clk),
      .reset(reset),
      .load(accept),
      .zero(zload),
      .run(run),
      .fin(fin),
      .a(a[c*A_W +: A_W]),
      .b(b_r),
      .q(q[c*Q_W +: Q_W]),
      .sat(sat[c])
    );
  end
endmodule
